hazard_ctrl: RTL

//  Pipeline sequencer for the IF/ID, ID/EX and EX/MEM buffers and the PC register.

---
 rtl/hazard_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use bubbles, taken branch/jump redirect and flush.
// Optional HAZARD_PERF_EN builds saturating stall/redirect event counters.
module hazard_ctrl #(
    parameter int REG_AW    = 6,
    parameter int STALL_CYC = 1,
    parameter int FLUSH_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_mem_read,
    input  logic              ex_reg_wr,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_branch_neg,
    input  logic              mem_branch_zero,
    input  logic              mem_n,
    input  logic              mem_z,
    input  logic              mem_jump,
    input  logic              mem_jump_mem,
    output logic              pc_en,
    output logic              if_en,
    output logic              if_flush,
    output logic              id_flush,
    output logic              ex_flush,
    output logic              redirect,
    output logic [1:0]        state_o,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
);

    // state | meaning
    // RUN   | normal issue; first bubble of a load-use hazard is raised from here
    // STALL | remaining load-use bubbles, PC and IF/ID held
    // FLUSH | extra IF/ID flush cycles while the redirected fetch returns
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [3:0] STALL_LOAD = (STALL_CYC > 1) ? 4'(STALL_CYC - 2) : 4'd0;
    localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYC > 0) ? 4'(FLUSH_CYC - 1) : 4'd0;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       taken;
    logic       lu;

    assign taken = (mem_branch_neg & mem_n) | (mem_branch_zero & mem_z)
                 | mem_jump | mem_jump_mem;

    assign lu = ex_mem_read & ex_reg_wr & (ex_rd != '0)
              & ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (taken) begin
            if (FLUSH_CYC > 0) begin
                state_d = ST_FLUSH;
                cnt_d   = FLUSH_LOAD;
            end else begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    // a single-bubble hazard is fully served by the RUN cycle itself
                    if (lu && (STALL_CYC > 1)) begin
                        state_d = ST_STALL;
                        cnt_d   = STALL_LOAD;
                    end
                end
                ST_STALL, ST_FLUSH: begin
                    if (cnt_q == 4'd0) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        pc_en    = 1'b1;
        if_en    = 1'b1;
        if_flush = 1'b0;
        id_flush = 1'b0;
        ex_flush = 1'b0;
        redirect = 1'b0;
        if (!rst_n) begin
            pc_en    = 1'b0;
            if_en    = 1'b0;
            if_flush = 1'b1;
            id_flush = 1'b1;
            ex_flush = 1'b1;
        end else if (taken) begin
            redirect = 1'b1;
            if_flush = 1'b1;
            id_flush = 1'b1;
            ex_flush = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (lu) begin
                        pc_en    = 1'b0;
                        if_en    = 1'b0;
                        id_flush = 1'b1;
                    end
                end
                ST_STALL: begin
                    pc_en    = 1'b0;
                    if_en    = 1'b0;
                    id_flush = 1'b1;
                end
                ST_FLUSH: begin
                    if_flush = 1'b1;
                end
                default: begin
                    pc_en = 1'b1;
                end
            endcase
        end
    end

    assign state_o = state_q;

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (id_flush && !redirect && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (redirect && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
